// File: rtl/acc_apb_master.sv
// acc_apb_master: single-outstanding request/response to APB master bridge.
// Define ACC_APB_TIMEOUT_EN to add an ACCESS-phase watchdog that aborts stalled transfers.
module acc_apb_master #(
    parameter int APB_ADDR_WIDTH = 13,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [APB_ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]               req_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [31:0]               rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    state_t state;
    assign req_ready = (state == IDLE);
`ifdef ACC_APB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;
    logic          expired;
    // The current stalled cycle is the TIMEOUT_CYCLES-th consecutive wait.
    assign expired = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    // Tied low; the comparison is constant false and only keeps the parameter referenced.
    assign rsp_timeout = (TIMEOUT_CYCLES < 0);
`endif
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= IDLE;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
`ifdef ACC_APB_TIMEOUT_EN
            rsp_timeout <= 1'b0;
            wait_cnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    state  <= SETUP;
                    PSEL   <= 1'b1;
                    PADDR  <= req_addr;
                    PWRITE <= req_write;
                    PWDATA <= req_write ? req_wdata : 32'd0;
                end
                SETUP: begin
                    state   <= ACCESS;
                    PENABLE <= 1'b1;
`ifdef ACC_APB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                ACCESS: if (PREADY) begin
                    state     <= RESP;
                    PSEL      <= 1'b0;
                    PENABLE   <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= PWRITE ? 32'd0 : PRDATA;
                    rsp_err   <= PSLVERR;
`ifdef ACC_APB_TIMEOUT_EN
                    rsp_timeout <= 1'b0;
                end else if (expired) begin
                    state       <= RESP;
                    PSEL        <= 1'b0;
                    PENABLE     <= 1'b0;
                    rsp_valid   <= 1'b1;
                    rsp_rdata   <= 32'd0;
                    rsp_err     <= 1'b1;
                    rsp_timeout <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
`endif
                end
                RESP: if (rsp_ready) begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_acc_apb_master.sv
// tb_acc_apb_master: randomized transactions checked against a transaction-level model.
// Predicts access length, response fields and timeout from the transfer parameters alone.
module tb_acc_apb_master;
    localparam int AW = 13;
    localparam int TO = 8;
`ifdef ACC_APB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    logic          HCLK = 1'b0, HRESETn = 1'b0;
    logic          req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_wdata = '0, PRDATA = '0;
    logic          PREADY = 1'b0, PSLVERR = 1'b0;
    logic          req_ready, rsp_valid, rsp_err, rsp_timeout, PWRITE, PSEL, PENABLE;
    logic [31:0]   rsp_rdata, PWDATA;
    logic [AW-1:0] PADDR;
    int n_chk = 0, n_pass = 0;

    acc_apb_master #(.APB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge HCLK);
        #1;
    endtask

    task automatic xfer(input bit wr, input logic [AW-1:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int waits, input bit slverr, input int hold);
        bit          to, stable, held;
        int          n, exp_n;
        logic [31:0] pw, exp_rd;
        to     = TO_EN && waits >= TO;
        exp_n  = to ? TO : waits + 1;
        pw     = wr ? wdata : 32'd0;
        exp_rd = (wr || to) ? 32'd0 : rdata;
        check("idle_req_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
        tick;
        req_valid = 1'b0; req_write = 1'($urandom); req_addr = AW'($urandom); req_wdata = $urandom;
        check("setup_sel_en", 32'({PSEL, PENABLE, req_ready}), 32'b100);
        check("setup_paddr", 32'(PADDR), 32'(addr));
        check("setup_pwrite", 32'(PWRITE), 32'(wr));
        check("setup_pwdata", PWDATA, pw);
        tick;
        n = 0;
        stable = 1'b1;
        while (PENABLE && n < 64) begin
            stable &= PSEL && PADDR == addr && PWRITE == wr && PWDATA == pw && !rsp_valid;
            PREADY  = (n == waits);
            PRDATA  = (n == waits) ? rdata : $urandom;
            PSLVERR = (n == waits) ? slverr : 1'($urandom);
            tick;
            n++;
        end
        PREADY = 1'b0; PSLVERR = 1'b0;
        check("access_cycles", 32'(n), 32'(exp_n));
        check("access_stable", 32'(stable), 32'd1);
        check("rsp_flags", 32'({rsp_valid, rsp_err, rsp_timeout, PSEL, PENABLE}),
              32'({1'b1, to | slverr, to, 2'b00}));
        check("rsp_rdata", rsp_rdata, exp_rd);
        held = 1'b1;
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            tick;
            held &= rsp_valid && rsp_rdata == exp_rd && rsp_err == (to | slverr) &&
                    rsp_timeout == to && !req_ready && !PSEL;
        end
        req_valid = 1'b0;
        check("rsp_hold", 32'(held), 32'd1);
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        check("rsp_release", 32'({rsp_valid, req_ready}), 32'b01);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        #12;
        check("reset_ctrl", 32'({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout}), 32'd0);
        check("reset_paddr_pwdata", 32'(PADDR) | PWDATA, 32'd0);
        check("reset_rdata", rsp_rdata, 32'd0);
        HRESETn = 1'b1;
        check("post_reset_ready", 32'(req_ready), 32'd1);
        tick;
        xfer(1'b1, 13'h000, 32'h1, 32'h0, 0, 1'b0, 0);
        xfer(1'b0, 13'h010, 32'h0, 32'hDEADBEEF, 5, 1'b0, 1);
        xfer(1'b0, 13'h020, 32'h0, 32'h5A5A1234, 0, 1'b1, 4);
        xfer(1'b0, 13'h030, 32'h0, 32'h0BADF00D, TO - 1, 1'b0, 0);
        xfer(1'b0, 13'h034, 32'h0, 32'h12345678, TO + 2, 1'b0, 2);
        // Reset pulse in the middle of a stalled ACCESS phase.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 13'h040;
        tick;
        req_valid = 1'b0;
        tick;
        check("pre_reset_access", 32'({PSEL, PENABLE}), 32'b11);
        #2 HRESETn = 1'b0;
        #1 check("mid_reset_drop", 32'({PSEL, PENABLE, rsp_valid}), 32'd0);
        tick;
        HRESETn = 1'b1;
        check("mid_reset_ready", 32'({req_ready, rsp_valid}), 32'b10);
        tick;
        check("mid_reset_no_rsp", 32'({rsp_valid, PSEL}), 32'd0);
        xfer(1'b1, 13'h044, 32'hCAFEF00D, 32'h0, 1, 1'b0, 0);
        for (int k = 0; k < 40; k++)
            xfer(1'($urandom), AW'($urandom), $urandom, $urandom, int'($urandom_range(0, 11)),
                 1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
